// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared UDP framing types and constants for the tx and rx paths
package eth_pkg;

  localparam int LEN_UDP_HEADER  = 8;
  localparam int MAX_UDP_PAYLOAD = 1472;

  typedef enum logic [2:0] {
    UDP_TX_IDLE             = 3'd0,
    UDP_TX_PORT_SOURCE      = 3'd1,
    UDP_TX_PORT_DESTINATION = 3'd2,
    UDP_TX_LENGTH           = 3'd3,
    UDP_TX_CHECKSUM         = 3'd4,
    UDP_TX_PAYLOAD          = 3'd5
  } udp_tx_state_t;

  // Header fields go out MSB first: index 0 is the high byte.
  function automatic logic [7:0] hdr_byte(input logic [15:0] field, input logic idx);
    return idx ? field[7:0] : field[15:8];
  endfunction

endpackage

// File: rtl/udp_header_tx_if.sv
// rtl/udp_header_tx_if.sv - request, payload stream and output stream of the UDP header transmitter
interface udp_header_tx_if;

  logic        start;
  logic [15:0] port_s;
  logic [15:0] port_d;
  logic [15:0] payload_len;
  logic        busy;
  logic        len_err;
  logic        done;

  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        payload_ready;

  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic        data_last;

  modport slave (
    input  start, port_s, port_d, payload_len,
    output busy, len_err, done,
    input  payload_data, payload_valid,
    output payload_ready,
    output data_out, data_valid, data_last,
    input  data_ready
  );

  modport master (
    output start, port_s, port_d, payload_len,
    input  busy, len_err, done,
    output payload_data, payload_valid,
    input  payload_ready,
    input  data_out, data_valid, data_last,
    output data_ready
  );

endinterface

// File: rtl/udp_header_tx.sv
// rtl/udp_header_tx.sv - prepends the 8-byte UDP header (checksum 0) to a byte-wide payload stream
module udp_header_tx
  import eth_pkg::*;
#(
  parameter int MAX_PAYLOAD = MAX_UDP_PAYLOAD
) (
  input  logic          aclk,
  input  logic          areset,
  udp_header_tx_if.slave bus
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
  localparam logic [15:0] HDR_LEN = 16'(LEN_UDP_HEADER);

  udp_tx_state_t state_q, state_d;
  logic          byte_idx_q, byte_idx_d;
  logic [10:0]   cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          len_err_q, len_err_d;

  logic [15:0]   port_s_q;
  logic [15:0]   port_d_q;
  logic [15:0]   payload_len_q;
  logic [15:0]   udp_len_q;

  logic          accept;
  logic          last_payload;
  logic [7:0]    data_out_c;
  logic          data_valid_c;
  logic          data_last_c;
  logic          payload_ready_c;

  assign accept       = (state_q == UDP_TX_IDLE) && bus.start && (bus.payload_len <= MAX_LEN);
  assign last_payload = ({5'd0, cnt_q} == (payload_len_q - 16'd1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= UDP_TX_IDLE;
      byte_idx_q <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
    end
  end

  // Request fields are only meaningful while busy, so they need no reset.
  always_ff @(posedge aclk) begin
    if (accept) begin
      port_s_q      <= bus.port_s;
      port_d_q      <= bus.port_d;
      payload_len_q <= bus.payload_len;
      udp_len_q     <= bus.payload_len + HDR_LEN;
    end
  end

  always_comb begin
    state_d         = state_q;
    byte_idx_d      = byte_idx_q;
    cnt_d           = cnt_q;
    done_d          = 1'b0;
    len_err_d       = 1'b0;
    data_out_c      = 8'h00;
    data_valid_c    = 1'b0;
    data_last_c     = 1'b0;
    payload_ready_c = 1'b0;

    case (state_q)
      UDP_TX_IDLE: begin
        if (bus.start) begin
          if (bus.payload_len > MAX_LEN) begin
            len_err_d = 1'b1;
          end else begin
            state_d    = UDP_TX_PORT_SOURCE;
            byte_idx_d = 1'b0;
          end
        end
      end

      UDP_TX_PORT_SOURCE: begin
        data_valid_c = 1'b1;
        data_out_c   = hdr_byte(port_s_q, byte_idx_q);
        if (bus.data_ready) begin
          byte_idx_d = ~byte_idx_q;
          if (byte_idx_q) state_d = UDP_TX_PORT_DESTINATION;
        end
      end

      UDP_TX_PORT_DESTINATION: begin
        data_valid_c = 1'b1;
        data_out_c   = hdr_byte(port_d_q, byte_idx_q);
        if (bus.data_ready) begin
          byte_idx_d = ~byte_idx_q;
          if (byte_idx_q) state_d = UDP_TX_LENGTH;
        end
      end

      UDP_TX_LENGTH: begin
        data_valid_c = 1'b1;
        data_out_c   = hdr_byte(udp_len_q, byte_idx_q);
        if (bus.data_ready) begin
          byte_idx_d = ~byte_idx_q;
          if (byte_idx_q) state_d = UDP_TX_CHECKSUM;
        end
      end

      UDP_TX_CHECKSUM: begin
        // Checksum is always zero; a zero-length datagram ends here.
        data_valid_c = 1'b1;
        data_out_c   = 8'h00;
        data_last_c  = byte_idx_q && (payload_len_q == 16'd0);
        if (bus.data_ready) begin
          byte_idx_d = ~byte_idx_q;
          if (byte_idx_q) begin
            if (payload_len_q != 16'd0) begin
              state_d = UDP_TX_PAYLOAD;
            end else begin
              state_d = UDP_TX_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end

      UDP_TX_PAYLOAD: begin
        data_out_c      = bus.payload_data;
        data_valid_c    = bus.payload_valid;
        payload_ready_c = bus.data_ready;
        data_last_c     = last_payload;
        if (bus.payload_valid && bus.data_ready) begin
          if (last_payload) begin
            cnt_d   = '0;
            state_d = UDP_TX_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 11'd1;
          end
        end
      end

      default: begin
        state_d = UDP_TX_IDLE;
      end
    endcase
  end

  assign bus.data_out      = data_out_c;
  assign bus.data_valid    = data_valid_c;
  assign bus.data_last     = data_last_c;
  assign bus.payload_ready = payload_ready_c;
  assign bus.busy          = (state_q != UDP_TX_IDLE);
  assign bus.done          = done_q;
  assign bus.len_err       = len_err_q;

endmodule

// File: tb/tb_udp_header_tx.sv
// tb/tb_udp_header_tx.sv - directed bench for udp_header_tx with a frame-level byte-queue model
module tb_udp_header_tx;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  udp_header_tx_if bus ();

  udp_header_tx #(.MAX_PAYLOAD(1472)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Stimulus state
  logic [7:0] pay_q[$];
  logic [7:0] next_pay[$];
  logic [7:0] stim_pay[$];
  int         rdy_mode = 0;
  bit         gap_armed = 0;
  int         gap_rem = 0;
  int         gap_cnt = 0;
  bit         drv_take;

  // Model / monitor state
  logic [7:0] exp_q[$];
  int         m_hdr_left = 0;
  bit         m_busy = 0;
  bit         m_done = 0;
  bit         m_len_err = 0;
  bit         m_cur_busy;
  bit         chk_en = 0;
  bit         ev;
  bit         er;
  bit         prev_hold = 0;
  logic [7:0] prev_out;
  logic [15:0] m_ul;
  logic [7:0] cap_q[$];
  int         cap_cyc[$];
  int         start_cyc = 0;
  int         pready_seen = 0;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Payload source and downstream ready pattern
  initial begin
    bus.payload_valid = 1'b0;
    bus.payload_data  = 8'h00;
    bus.data_ready    = 1'b1;
    forever begin
      @(negedge aclk);
      drv_take = bus.payload_valid && bus.payload_ready;
      @(posedge aclk);
      #1;
      if (drv_take && pay_q.size() > 0) begin
        void'(pay_q.pop_front());
        if (gap_armed && pay_q.size() == gap_rem) begin
          gap_cnt   = 3;
          gap_armed = 0;
        end
      end
      if (gap_cnt > 0) begin
        gap_cnt--;
        bus.payload_valid = 1'b0;
      end else begin
        bus.payload_valid = (pay_q.size() > 0);
      end
      if (pay_q.size() > 0) bus.payload_data = pay_q[0];
      bus.data_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    end
  end

  // Model: a datagram is the header bytes followed by the payload, one byte per transfer
  initial begin
    forever begin
      @(negedge aclk);
      ev = m_busy && (m_hdr_left > 0 || bus.payload_valid);
      er = bus.data_ready;
      if (chk_en) begin
        chk("busy", bus.busy, m_busy);
        chk("done", bus.done, m_done);
        chk("len_err", bus.len_err, m_len_err);
        chk("data_valid", bus.data_valid, ev);
        chk("payload_ready", bus.payload_ready, m_busy && m_hdr_left == 0 && er);
        if (ev) begin
          chk("data_out", bus.data_out, exp_q[0]);
          chk("data_last", bus.data_last, exp_q.size() == 1);
        end
        if (prev_hold) chk("hold", bus.data_out, prev_out);
      end
      if (bus.payload_ready) pready_seen++;
      prev_hold  = ev && !er;
      prev_out   = bus.data_out;
      m_cur_busy = m_busy;
      m_done     = 0;
      m_len_err  = 0;
      if (areset) begin
        exp_q.delete();
        m_hdr_left = 0;
        m_busy     = 0;
        prev_hold  = 0;
      end else begin
        if (ev && er) begin
          cap_q.push_back(bus.data_out);
          cap_cyc.push_back(cyc);
          void'(exp_q.pop_front());
          if (m_hdr_left > 0) m_hdr_left--;
          if (exp_q.size() == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
        if (!m_cur_busy && bus.start) begin
          if (bus.payload_len > 16'd1472) begin
            m_len_err = 1;
          end else begin
            m_ul = bus.payload_len + 16'd8;
            exp_q.delete();
            exp_q.push_back(bus.port_s[15:8]);
            exp_q.push_back(bus.port_s[7:0]);
            exp_q.push_back(bus.port_d[15:8]);
            exp_q.push_back(bus.port_d[7:0]);
            exp_q.push_back(m_ul[15:8]);
            exp_q.push_back(m_ul[7:0]);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            foreach (stim_pay[i]) exp_q.push_back(stim_pay[i]);
            m_hdr_left = 8;
            m_busy     = 1;
            start_cyc  = cyc;
          end
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] ps, input logic [15:0] pd,
                          input logic [15:0] len, input bit push);
    bus.start       = 1'b1;
    bus.port_s      = ps;
    bus.port_d      = pd;
    bus.payload_len = len;
    if (push) begin
      stim_pay = next_pay;
      foreach (next_pay[i]) pay_q.push_back(next_pay[i]);
      cap_q.delete();
      cap_cyc.delete();
      pready_seen = 0;
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    chk(name, bus.done, 1'b1);
  endtask

  task automatic check_cap(input string name, input logic [7:0] want[$]);
    chk({name, "_count"}, cap_q.size(), want.size());
    foreach (want[i]) if (i < cap_q.size()) chk(name, cap_q[i], want[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    areset          = 1'b1;
    bus.start       = 1'b0;
    bus.port_s      = '0;
    bus.port_d      = '0;
    bus.payload_len = '0;
    repeat (3) tick();
    areset = 1'b0;
    chk_en = 1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_valid", bus.data_valid, 1'b0);
    chk("rst_pready", bus.payload_ready, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    tick();

    // Basic frame, ready held high
    next_pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_start(16'h1234, 16'h0050, 16'd4, 1);
    wait_done(100, "t1_done");
    check_cap("t1_bytes", {8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00,
                           8'hAA, 8'hBB, 8'hCC, 8'hDD});
    if (cap_cyc.size() == 12) begin
      chk("t1_latency", cap_cyc[0] - start_cyc, 1);
      chk("t1_span", cap_cyc[11] - cap_cyc[0], 11);
    end
    tick();

    // Same frame with backpressure and a payload gap
    rdy_mode  = 1;
    gap_rem   = 2;
    gap_armed = 1;
    do_start(16'h1234, 16'h0050, 16'd4, 1);
    wait_done(200, "t2_done");
    check_cap("t2_bytes", {8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00,
                           8'hAA, 8'hBB, 8'hCC, 8'hDD});
    rdy_mode = 0;
    tick();

    // Zero-length payload
    next_pay.delete();
    do_start(16'hFFFF, 16'h0001, 16'd0, 1);
    wait_done(100, "t3_done");
    check_cap("t3_bytes", {8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h08, 8'h00, 8'h00});
    chk("t3_pready_seen", pready_seen, 0);
    tick();

    // Length limit: 1473 rejected, 1472 accepted
    do_start(16'h0102, 16'h0304, 16'd1473, 0);
    chk("t4_len_err", bus.len_err, 1'b1);
    chk("t4_busy", bus.busy, 1'b0);
    chk("t4_valid", bus.data_valid, 1'b0);
    tick();
    chk("t4_len_err_pulse", bus.len_err, 1'b0);
    next_pay.delete();
    for (int i = 0; i < 1472; i++) next_pay.push_back(8'(i * 7));
    do_start(16'h0102, 16'h0304, 16'd1472, 1);
    wait_done(3000, "t4_done");
    chk("t4_count", cap_q.size(), 1480);
    if (cap_q.size() > 5) begin
      chk("t4_len_hi", cap_q[4], 8'h05);
      chk("t4_len_lo", cap_q[5], 8'hC8);
    end
    tick();

    // Reset in the middle of the payload, then a clean frame
    next_pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_start(16'h1111, 16'h2222, 16'd4, 1);
    n = 0;
    while (pay_q.size() != 2 && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("t5_reached_payload", pay_q.size(), 2);
    @(posedge aclk);
    #1;
    areset = 1'b1;
    @(negedge aclk);
    pay_q.delete();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_valid", bus.data_valid, 1'b0);
    chk("t5_last", bus.data_last, 1'b0);
    chk("t5_pready", bus.payload_ready, 1'b0);
    chk("t5_done", bus.done, 1'b0);
    repeat (3) tick();
    next_pay = {8'h01, 8'h02, 8'h03};
    do_start(16'h0A0B, 16'h0C0D, 16'd3, 1);
    wait_done(100, "t5_after_done");
    check_cap("t5_bytes", {8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00, 8'h0B, 8'h00, 8'h00,
                           8'h01, 8'h02, 8'h03});
    tick();

    // Start while busy is ignored; start on the done cycle is accepted
    next_pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_start(16'h1234, 16'h0050, 16'd4, 1);
    repeat (2) tick();
    do_start(16'h9999, 16'h8888, 16'd4, 0);
    do_start(16'h7777, 16'h6666, 16'd1473, 0);
    chk("t6_no_len_err", bus.len_err, 1'b0);
    wait_done(100, "t6_a_done");
    check_cap("t6_a_bytes", {8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'h00, 8'h00,
                             8'hAA, 8'hBB, 8'hCC, 8'hDD});
    next_pay = {8'h5A, 8'hA5};
    do_start(16'hABCD, 16'h0007, 16'd2, 1);
    wait_done(100, "t6_b_done");
    check_cap("t6_b_bytes", {8'hAB, 8'hCD, 8'h00, 8'h07, 8'h00, 8'h0A, 8'h00, 8'h00,
                             8'h5A, 8'hA5});
    if (cap_cyc.size() > 0) chk("t6_b_latency", cap_cyc[0] - start_cyc, 1);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_header_tx.md
Name: udp_header_tx

Overview:
Transmit-side UDP encapsulator. It prepends an 8-byte UDP header (source port, destination port, length, checksum) to a byte-wide payload stream and emits the result byte-serially toward the IP header transmitter. It pairs with the UDP receive path, which strips and checks the same header. Checksum is sent as 0x0000, which is legal for UDP over IPv4.

Parameters:
MAX_PAYLOAD, 1472, largest accepted payload length in bytes (1500 MTU - 20 IP - 8 UDP)
LEN_UDP_HEADER, 8, UDP header length in bytes; fixed, do not override

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; fields below are sampled on the same cycle
port_s  in  16  source port
port_d  in  16  destination port
payload_len  in  16  payload byte count, excluding the header
busy  out  1  high from accepted start until the cycle done pulses
len_err  out  1  one-cycle pulse when start is rejected because payload_len > MAX_PAYLOAD
payload_data  in  8  payload byte
payload_valid  in  1  payload_data is valid
payload_ready  out  1  block is consuming payload this cycle
data_out  out  8  output byte
data_valid  out  1  data_out is valid
data_ready  in  1  downstream accepts data_out
data_last  out  1  marks the final byte of the datagram
done  out  1  one-cycle pulse on the cycle after the last byte transfers

Behaviour:
- Reset (areset=1 on a rising edge): state=IDLE, byte counter=0, busy=0, len_err=0, done=0, data_valid=0, data_last=0, payload_ready=0. Latched fields may be left unreset. Reset during any state aborts the frame with no done pulse.
- States: IDLE, PORT_SOURCE, PORT_DESTINATION, LENGTH, CHECKSUM, PAYLOAD. Every header state spans two bytes, MSB first, with a 1-bit byte index.
- A transfer happens on any cycle where data_valid & data_ready. State and counters advance only on a transfer.
- IDLE, start=1, payload_len <= MAX_PAYLOAD:
  - latch port_s, port_d, payload_len, and udp_len = payload_len + 8 (16-bit);
  - go to PORT_SOURCE; busy=1 from the next cycle.
- IDLE, start=1, payload_len > MAX_PAYLOAD: stay in IDLE; pulse len_err for one cycle; busy stays 0.
- start while busy=1 is ignored and produces no error.
- Header states:
  - data_valid=1; data_out is a combinational mux of the latched fields selected by state and byte index;
  - byte sequence: port_s[15:8], port_s[7:0], port_d[15:8], port_d[7:0], udp_len[15:8], udp_len[7:0], 0x00, 0x00;
  - payload_ready=0.
- Leaving CHECKSUM: after the second checksum byte transfers, go to PAYLOAD if payload_len != 0, else back to IDLE. With zero payload, data_last=1 on the second checksum byte.
- PAYLOAD, zero-latency pass-through:
  - data_out=payload_data, data_valid=payload_valid, payload_ready=data_ready;
  - an 11-bit counter counts transfers; data_last=1 when counter == payload_len-1;
  - on the last transfer: counter returns to 0 and state returns to IDLE.
- payload_valid=0 mid-payload makes data_valid=0; the block waits indefinitely with no timeout.
- data_ready=0 holds data_out and the state stable (AXI-Stream-like rule). data_valid, once high in a header state, must not drop before its transfer.
- done pulses for one cycle and busy falls on the cycle after the final transfer. A new start is accepted in that same cycle.
- Latency: with data_ready=1 held high, the first header byte appears the cycle after start. Throughput is one byte per cycle.

Decomposition:
- Shared package eth_pkg holds:
  - the state enum typedef udp_tx_state_t (logic [2:0]);
  - LEN_UDP_HEADER = 8;
  - MAX_UDP_PAYLOAD = 1472.
  The rx and tx UDP blocks both use it.
- No sub-module: the header byte mux sits inline. A separate mux module would be a thin wrapper.

Test Plan:
1. start with port_s=0x1234, port_d=0x0050, payload_len=4; payload AA BB CC DD; data_ready=1 -> output 12 34 00 50 00 0C 00 00 AA BB CC DD. data_last only on DD; done one cycle later; 12 bytes in 12 consecutive cycles.
2. Same frame with data_ready toggled 1,0,0,1,... and payload_valid dropping for 3 cycles mid-payload -> identical byte sequence, no byte lost or duplicated, data_out stable whenever data_valid & !data_ready.
3. payload_len=0, port_s=0xFFFF, port_d=0x0001 -> FF FF 00 01 00 08 00 00, data_last on the final 00, payload_ready never asserted.
4. payload_len=1473 -> len_err one-cycle pulse, busy=0, data_valid=0. payload_len=1472 -> accepted, length field 0x05C8.
5. areset=1 during the PAYLOAD byte 2 of frame 1 -> all outputs at reset values next cycle, no done. A following start sends a complete, correct frame.
6. start pulsed again while busy, then immediately on the done cycle -> the first pulse is ignored; the second frame starts the following cycle with its own latched fields.
